// File: rtl/delay_monitor_if.sv
// Bundles the monitored pulse input with the status outputs of delay_monitor.
interface delay_monitor_if;
  logic        sig;
  logic        locked;
  logic        early;
  logic        late;
  logic        err;
  logic [15:0] good_cnt;

  modport master (output sig, input locked, early, late, err, good_cnt);
  modport slave  (input sig, output locked, early, late, err, good_cnt);
endinterface

// File: rtl/delay_monitor.sv
// Checks that sig pulses arrive every N+1 clock edges, tracking lock, early/late events and good intervals.
// Optional feature macro DELAY_MON_TOL_EN widens the accepted gap to N+1 +/- TOL.
module delay_monitor #(
  parameter int N     = 400000,
  parameter int CBITS = 19,
  parameter int TOL   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  delay_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;

`ifdef DELAY_MON_TOL_EN
  localparam int TOL_EFF = TOL;
`else
  // exact matching: tolerance collapses to zero
  localparam int TOL_EFF = 0 * TOL;
`endif
  localparam logic [CBITS-1:0] LO = CBITS'(N + 1 - TOL_EFF);
  localparam logic [CBITS-1:0] HI = CBITS'(N + 1 + TOL_EFF);

  logic [1:0]       rsync;
  logic             rst_i_n;
  state_t           state, state_nx;
  logic [CBITS-1:0] gcnt;
  logic             in_win, is_early;
  logic             early_nx, late_nx, good_inc;
  logic             locked_q, early_q, late_q, err_q;
  logic [15:0]      good_q;

  // Asserts immediately, releases two edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync <= '0;
    else        rsync <= {rsync[0], 1'b1};
  end
  assign rst_i_n = rsync[1];

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n)      gcnt <= '0;
    else if (mon.sig)  gcnt <= CBITS'(1);
    else if (gcnt != '1) gcnt <= gcnt + 1'b1;
  end

  assign in_win   = (gcnt >= LO) && (gcnt <= HI);
  assign is_early = (gcnt < LO);

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (mon.sig) state_nx = SYNC;
      SYNC, LOCK: begin
        if (mon.sig)         state_nx = in_win ? LOCK : SYNC;
        else if (gcnt == HI) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Late is only judged outside IDLE, so a saturated gcnt cannot re-fire it
  always_comb begin
    early_nx = 1'b0;
    late_nx  = 1'b0;
    good_inc = 1'b0;
    if (state != IDLE) begin
      if (mon.sig) begin
        if (in_win)        good_inc = 1'b1;
        else if (is_early) early_nx = 1'b1;
      end else if (gcnt == HI) begin
        late_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      locked_q <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      err_q    <= 1'b0;
      good_q   <= '0;
    end else begin
      locked_q <= (state_nx == LOCK);
      early_q  <= early_nx;
      late_q   <= late_nx;
      err_q    <= err_q | early_nx | late_nx;
      if (good_inc && good_q != '1) good_q <= good_q + 16'd1;
    end
  end

  assign mon.locked   = locked_q;
  assign mon.early    = early_q;
  assign mon.late     = late_q;
  assign mon.err      = err_q;
  assign mon.good_cnt = good_q;

endmodule

// File: tb/tb_delay_monitor.sv
// Directed bench for delay_monitor with N=10, CBITS=5, TOL=2.
module tb_delay_monitor;
  localparam int N     = 10;
  localparam int CBITS = 5;
  localparam int TOL   = 2;
`ifdef DELAY_MON_TOL_EN
  localparam int LATE_AT = 13;
`else
  localparam int LATE_AT = 11;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  delay_monitor_if mif ();

  delay_monitor #(.N(N), .CBITS(CBITS), .TOL(TOL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mif.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int n_early    = 0;
  int n_late     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s);
    mif.sig = s;
    @(posedge clk);
    #1;
    if (mif.early === 1'b1) n_early++;
    if (mif.late === 1'b1)  n_late++;
  endtask

  task automatic gap(input int g);
    repeat (g - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, {31'd0, mif.locked}, 32'd0);
    chk({tag, "_early"},  {31'd0, mif.early},  32'd0);
    chk({tag, "_late"},   {31'd0, mif.late},   32'd0);
    chk({tag, "_err"},    {31'd0, mif.err},    32'd0);
    chk({tag, "_good"},   {16'd0, mif.good_cnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mif.sig = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk_all_zero("reset");

    repeat (3) step(1'b0);
    rst_n = 1'b1;
    repeat (3) step(1'b0);
    n_early = 0;
    n_late  = 0;

    // lock acquisition: 5 pulses, 11 edges apart
    step(1'b1);
    chk("first_pulse_locked", {31'd0, mif.locked}, 32'd0);
    gap(11);
    chk("lock_2nd_locked", {31'd0, mif.locked}, 32'd1);
    chk("lock_2nd_good", {16'd0, mif.good_cnt}, 32'd1);
    repeat (3) gap(11);
    chk("lock5_good", {16'd0, mif.good_cnt}, 32'd4);
    chk("lock5_err", {31'd0, mif.err}, 32'd0);
    chk("lock5_locked", {31'd0, mif.locked}, 32'd1);
    chk("lock5_no_flags", n_early + n_late, 32'd0);

    // early pulse after 8 edges
    gap(8);
    chk("early_flag", {31'd0, mif.early}, 32'd1);
    chk("early_err", {31'd0, mif.err}, 32'd1);
    chk("early_locked", {31'd0, mif.locked}, 32'd0);
    chk("early_late", {31'd0, mif.late}, 32'd0);
    step(1'b0);
    chk("early_one_cycle", {31'd0, mif.early}, 32'd0);
    repeat (9) step(1'b0);
    step(1'b1);
    chk("relock_locked", {31'd0, mif.locked}, 32'd1);
    chk("relock_good", {16'd0, mif.good_cnt}, 32'd5);
    chk("relock_err_sticky", {31'd0, mif.err}, 32'd1);

    // missing pulse
    n_late = 0;
    repeat (LATE_AT - 1) step(1'b0);
    chk("late_not_before", n_late, 32'd0);
    step(1'b0);
    chk("late_flag", {31'd0, mif.late}, 32'd1);
    chk("late_locked", {31'd0, mif.locked}, 32'd0);
    repeat (5) step(1'b0);
    chk("late_once", n_late, 32'd1);
    n_early = 0;
    step(1'b1);
    chk("resync_no_early", n_early, 32'd0);
    chk("resync_locked", {31'd0, mif.locked}, 32'd0);
    gap(11);
    chk("resync_lock", {31'd0, mif.locked}, 32'd1);
    chk("resync_good", {16'd0, mif.good_cnt}, 32'd6);

`ifdef DELAY_MON_TOL_EN
    n_early = 0;
    n_late  = 0;
    gap(9);
    chk("tol9_good", {16'd0, mif.good_cnt}, 32'd7);
    chk("tol9_locked", {31'd0, mif.locked}, 32'd1);
    gap(13);
    chk("tol13_good", {16'd0, mif.good_cnt}, 32'd8);
    chk("tol13_locked", {31'd0, mif.locked}, 32'd1);
    chk("tol_no_flags", n_early + n_late, 32'd0);
    gap(8);
    chk("tol8_early", {31'd0, mif.early}, 32'd1);
    chk("tol8_locked", {31'd0, mif.locked}, 32'd0);
`else
    gap(9);
    chk("exact9_early", {31'd0, mif.early}, 32'd1);
    chk("exact9_locked", {31'd0, mif.locked}, 32'd0);
    chk("exact9_good", {16'd0, mif.good_cnt}, 32'd6);
    gap(11);
    chk("exact_relock", {31'd0, mif.locked}, 32'd1);
    chk("exact_relock_good", {16'd0, mif.good_cnt}, 32'd7);
`endif

    // reset mid-interval while err is set
    repeat (4) step(1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) step(1'b0);
    rst_n = 1'b1;
    n_early = 0;
    n_late  = 0;
    repeat (16) step(1'b0);
    chk("post_reset_no_flags", n_early + n_late, 32'd0);
    chk("post_reset_err", {31'd0, mif.err}, 32'd0);
    chk("post_reset_locked", {31'd0, mif.locked}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
